// File: rtl/rsa_c_tb_collector_pkg.sv
// Shared definitions for the RSA C-output collector and the TB port-B lane mapper.
package rsa_c_tb_collector_pkg;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_POS  = 2'b01;
   localparam logic [1:0] DIR_NEG  = 2'b10;
   localparam logic [1:0] DIR_NEW  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } coll_state_e;

   function automatic logic dir_is_write(input logic [1:0] sel);
      return sel != DIR_IDLE;
   endfunction

endpackage

// File: rtl/rsa_c_tb_collector_lane_deskew.sv
// Staggered delay chain: lane i is held back X-1-i cycles so every lane lines up
// with lane X-1, whose valid bit becomes the aligned row-valid.
module rsa_c_tb_collector_lane_deskew #(
   parameter int X      = 4,
   parameter int RSA_DW = 16
) (
   input  logic                clk,
   input  logic                sys_rst,
   input  logic [X*RSA_DW-1:0] C_out,
   input  logic [X-1:0]        C_valid,
   output logic [X*RSA_DW-1:0] row_p0,
   output logic                vld_p0
);

   // Only the last lane's valid is meaningful once the lanes are aligned.
   logic unused_lane_vld;
   assign unused_lane_vld = ^C_valid[X-2:0];
   assign vld_p0          = C_valid[X-1];

   for (genvar i = 0; i < X; i++) begin : g_lane
      localparam int D = X - 1 - i;
      if (D == 0) begin : g_pass
         assign row_p0[i*RSA_DW +: RSA_DW] = C_out[i*RSA_DW +: RSA_DW];
      end else begin : g_dly
         logic [RSA_DW-1:0] sr [D];
         always_ff @(posedge clk or posedge sys_rst) begin
            if (sys_rst) begin
               for (int k = 0; k < D; k++) sr[k] <= '0;
            end else begin
               sr[0] <= C_out[i*RSA_DW +: RSA_DW];
               for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
            end
         end
         assign row_p0[i*RSA_DW +: RSA_DW] = sr[D-1];
      end
   end

endmodule

// File: rtl/rsa_c_tb_collector.sv
// Collects de-skewed RSA C rows and writes them to TB port B through the lane mapper,
// one job (start .. done) at a time.
module rsa_c_tb_collector
   import rsa_c_tb_collector_pkg::*;
#(
   parameter int X      = 4,
   parameter int RSA_DW = 16,
   parameter int TB_AW  = 10,
   parameter int CNT_W  = 8
) (
   input  logic                clk,
   input  logic                sys_rst,
   input  logic                start,
   input  logic [1:0]          dir,
   input  logic [TB_AW-1:0]    base_addr,
   input  logic [CNT_W-1:0]    row_num,
   input  logic [X*RSA_DW-1:0] C_out,
   input  logic [X-1:0]        C_valid,
   output logic [X*RSA_DW-1:0] C_TB_dinb,
   output logic [1:0]          TB_dinb_sel,
   output logic [TB_AW-1:0]    TB_addrb,
   output logic                TB_web,
   output logic                busy,
   output logic                done
);

   function automatic logic [TB_AW-1:0] row_addr(input logic [TB_AW-1:0] base,
                                                 input logic [CNT_W-1:0] k);
      return base + TB_AW'(k);
   endfunction

   logic [X*RSA_DW-1:0] row_p0;
   logic                vld_p0;

   coll_state_e         state_q, state_d;
   logic [1:0]          dir_q;
   logic [TB_AW-1:0]    base_q;
   logic [CNT_W-1:0]    row_num_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                latch;
   logic                accept;
   logic [TB_AW-1:0]    addr_p1;

   rsa_c_tb_collector_lane_deskew #(
      .X      (X),
      .RSA_DW (RSA_DW)
   ) u_deskew (
      .clk     (clk),
      .sys_rst (sys_rst),
      .C_out   (C_out),
      .C_valid (C_valid),
      .row_p0  (row_p0),
      .vld_p0  (vld_p0)
   );

   always_comb begin
      state_d = state_q;
      latch   = 1'b0;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               latch   = 1'b1;
               state_d = (row_num == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            // Once the quota is met, late rows are dropped while we drain.
            if (cnt_q == row_num_q) state_d = ST_FLUSH;
            else if (vld_p0)        accept  = 1'b1;
         end
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= ST_IDLE;
         dir_q     <= DIR_IDLE;
         base_q    <= '0;
         row_num_q <= '0;
         cnt_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= (state_q == ST_DONE);
         if (latch) begin
            dir_q     <= dir;
            base_q    <= base_addr;
            row_num_q <= row_num;
            cnt_q     <= '0;
            busy      <= 1'b1;
         end else if (state_q == ST_DONE) begin
            busy <= 1'b0;
         end
         if (accept) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Stage p1: aligned row and direction presented to the mapper.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         C_TB_dinb   <= '0;
         TB_dinb_sel <= DIR_IDLE;
         addr_p1     <= '0;
      end else begin
         TB_dinb_sel <= accept ? dir_q : DIR_IDLE;
         if (accept) begin
            C_TB_dinb <= row_p0;
            addr_p1   <= row_addr(base_q, cnt_q);
         end
      end
   end

   // Stage p2: address/enable lag one cycle to meet the mapper's registered output.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         TB_addrb <= '0;
         TB_web   <= 1'b0;
      end else begin
         TB_addrb <= addr_p1;
         TB_web   <= dir_is_write(TB_dinb_sel);
      end
   end

endmodule

// File: doc/rsa_c_tb_collector.md
Name: rsa_c_tb_collector

Overview:
- Sits between the RSA (systolic array) C-output ports and the TB port-B lane mapper (TB_dinb_map).
- De-skews the X staggered C lanes into aligned rows and drives C_TB_dinb/TB_dinb_sel into the mapper.
- Generates TB port-B address and write enable, delayed to line up with the mapper's registered TB_dinb.
- Controlled by a start/done job handshake from the top-level sequencer.

Parameters:
- X, 4, number of RSA output lanes
- RSA_DW, 16, data width per lane
- TB_AW, 10, TB port-B address width
- CNT_W, 8, width of the row-count field

Ports:
- clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle job start pulse; accepted only in IDLE
- dir  in  2  DIR_POS=01 or DIR_NEG=10, latched on start
- base_addr  in  TB_AW  first TB row address, latched on start
- row_num  in  CNT_W  number of aligned rows to write, latched on start
- C_out  in  X*RSA_DW  RSA lane data; lane i at bits [i*RSA_DW +: RSA_DW]
- C_valid  in  X  per-lane valid; lane i is asserted i cycles after lane 0
- C_TB_dinb  out  X*RSA_DW  aligned row to TB_dinb_map
- TB_dinb_sel  out  2  direction to TB_dinb_map; DIR_IDLE (00) when not writing
- TB_addrb  out  TB_AW  TB port-B address
- TB_web  out  1  TB port-B write enable
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle job completion pulse

Behaviour:
- Reset (async, sys_rst=1): all outputs 0, de-skew registers 0, FSM in IDLE.
- De-skew:
  - Lane i data is delayed X-1-i cycles through a shift chain; lane X-1 is not delayed.
  - Row-valid (rv) equals C_valid[X-1]. Lanes 0..X-2 valid bits are not checked.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: on start, latch dir, base_addr and row_num; clear the row counter; set busy=1.
    - row_num=0 → DONE.
    - Otherwise → RUN.
  - RUN: each rv=1 cycle registers the aligned row into C_TB_dinb with TB_dinb_sel=dir_q. Otherwise TB_dinb_sel=00 and C_TB_dinb holds its value.
    - Counter increments on each accepted row.
    - When the accepted count reaches row_num → FLUSH.
    - Any rv after the last row is ignored.
  - FLUSH: one cycle so the last write drains through the mapper → DONE.
  - DONE: done=1 for one cycle and busy=0 on the next edge → IDLE.
- Address/write alignment:
  - TB_addrb and TB_web lag C_TB_dinb/TB_dinb_sel by one extra register. This matches TB_dinb_map's one-cycle latency.
  - Write k (k from 0) uses address base_addr+k, modulo 2^TB_AW; wrap is silent.
- Latency:
  - rv at edge t → C_TB_dinb/TB_dinb_sel at t+1.
  - TB_dinb (mapper output), TB_addrb and TB_web at t+2.
- rv in IDLE/FLUSH/DONE: no write; TB_dinb_sel=00.
- start while busy: ignored; latched fields are unchanged.
- start in the same cycle as DONE: ignored; the job must re-issue start in IDLE.
- Reset mid-job: immediate return to IDLE, no done pulse, TB_web=0 asynchronously.

Decomposition:
- Shared package / include: DIR_IDLE/POS/NEG/NEW codes, shared with TB_dinb_map; FSM state encodings.
- Natural sub-module: rsa_lane_deskew, a parameterised X-lane staggered delay chain that outputs the aligned row and rv.

Test Plan:
- Single job: dir=01, base_addr=0x010, row_num=3; three skewed rows with lane values 0x1000+row*16+lane.
  - TB_web high for 3 cycles at addresses 0x010, 0x011, 0x012.
  - Mapper output equals the lane-ordered rows.
  - done fires 2 cycles after the last TB_web.
- Reverse direction: same stimulus with dir=10.
  - TB_dinb_sel=10 on all 3 writes.
  - Lane 0 of TB_dinb equals source lane X-1.
- Boundary conditions:
  - row_num=0 → done 2 cycles after start, TB_web never asserted.
  - base_addr=0x3FF with row_num=2 → writes to 0x3FF then 0x000.
- Gapped stream: rows separated by 2 idle cycles, plus one extra row after row_num=2.
  - Exactly 2 writes; TB_dinb_sel=00 on gap cycles; the extra row is ignored.
- Handshake corner: start asserted while busy with different base_addr.
  - Addresses continue from the original base; busy unchanged.
- Reset during RUN after 1 of 4 rows: sys_rst pulse mid-cycle.
  - TB_web=0 immediately; busy=0; no done pulse.
  - A following job with base_addr=0x020 starts cleanly at 0x020.
